vram_arbiter: RTL and testbench

Shares the single SDRAM memory-controller port between the VDP pixel/CPU access slot, a secondary auxiliary VRAM requester and periodic refresh. Runs in the 27 MHz VDP clock domain, sits between the VDP PRAM bus and the memory controller, and replaces the fixed read/write/refresh gating with a scheduled, handshaked sequencer. It also tracks refresh debt so refreshes are never lost when the idle slot is occupied.

---
 rtl/vram_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Schedules VDP, aux (macro VRAM_ARB_AUX_EN) and refresh accesses
//            onto the shared SDRAM controller port and tracks refresh debt.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
    parameter int REFRESH_INTERVAL = 200,
    parameter int MAX_DEBT         = 4,
    parameter int BUSY_TO          = 15
) (
    input  logic        clk_w,
    input  logic        reset_n_w,
    input  logic        slot_vdp,
    input  logic        slot_idle,
    input  logic        vdp_we_n,
    input  logic [16:0] vdp_adr,
    input  logic [7:0]  vdp_dbo,
    output logic [15:0] vdp_dbi,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [16:0] aux_adr,
    input  logic [7:0]  aux_dbo,
    output logic        aux_ack,
    output logic [7:0]  aux_dbi,
    output logic        mc_read,
    output logic        mc_write,
    output logic        mc_refresh,
    output logic [20:0] mc_addr,
    output logic [15:0] mc_din,
    output logic [1:0]  mc_wdm,
    input  logic [15:0] mc_dout,
    input  logic        mc_busy,
    output logic        timeout_err
);
    localparam int c_INTV_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int c_DEBT_W = $clog2(MAX_DEBT + 1);
    localparam int c_TO_W   = $clog2(BUSY_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_VDP = 2'd0,
        OWN_AUX = 2'd1,
        OWN_REF = 2'd2
    } owner_t;

    state_t              r_state, w_state_nxt;
    owner_t              r_owner, w_owner_nxt;
    logic                w_grant, w_timeout, w_done, w_wrap, w_dec;
    logic                r_busy_m, r_busy_s;
    logic                r_vdp_used, r_idle_used;
    logic                r_we;
    logic [15:0]         r_adr_lo;
    logic [7:0]          r_data;
    logic [1:0]          r_wdm;
    logic [15:0]         r_vdp_dbi;
    logic                r_timeout_err;
    logic [c_INTV_W-1:0] r_intv;
    logic [c_DEBT_W-1:0] r_debt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                w_aux_req, w_aux_we;
    logic [16:0]         w_aux_adr;
    logic [7:0]          w_aux_dbo;

`ifdef VRAM_ARB_AUX_EN
    logic       r_aux_ack;
    logic [7:0] r_aux_dbi;

    // A request still high during its own ack cycle must not be granted again.
    assign w_aux_req = aux_req & ~r_aux_ack;
    assign w_aux_we  = aux_we;
    assign w_aux_adr = aux_adr;
    assign w_aux_dbo = aux_dbo;

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_aux_ack <= 1'b0;
            r_aux_dbi <= 8'h00;
        end else begin
            r_aux_ack <= w_done && (r_owner == OWN_AUX);
            if (w_done && (r_owner == OWN_AUX) && !r_we)
                r_aux_dbi <= r_wdm[0] ? mc_dout[15:8] : mc_dout[7:0];
        end
    end

    assign aux_ack = r_aux_ack;
    assign aux_dbi = r_aux_dbi;
`else
    logic w_unused_aux;
    assign w_unused_aux = ^{aux_req, aux_we, aux_adr, aux_dbo};
    assign w_aux_req    = 1'b0;
    assign w_aux_we     = 1'b0;
    assign w_aux_adr    = 17'h0;
    assign w_aux_dbo    = 8'h00;
    assign aux_ack      = 1'b0;
    assign aux_dbi      = 8'h00;
`endif

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_busy_m <= 1'b0;
            r_busy_s <= 1'b0;
            r_state  <= S_IDLE;
            r_owner  <= OWN_VDP;
        end else begin
            r_busy_m <= mc_busy;
            r_busy_s <= r_busy_m;
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_grant     = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        mc_read     = 1'b0;
        mc_write    = 1'b0;
        mc_refresh  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_busy_s) begin
                    if (slot_vdp && !r_vdp_used) begin
                        w_grant     = 1'b1;
                        w_owner_nxt = OWN_VDP;
                    end else if (slot_idle && !r_idle_used) begin
                        if (r_debt == c_DEBT_W'(MAX_DEBT)) begin
                            w_grant     = 1'b1;
                            w_owner_nxt = OWN_REF;
                        end else if (w_aux_req) begin
                            w_grant     = 1'b1;
                            w_owner_nxt = OWN_AUX;
                        end else if (r_debt != '0) begin
                            w_grant     = 1'b1;
                            w_owner_nxt = OWN_REF;
                        end
                    end
                end
                if (w_grant)
                    w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                mc_refresh  = (r_owner == OWN_REF);
                mc_read     = (r_owner != OWN_REF) && !r_we;
                mc_write    = (r_owner != OWN_REF) && r_we;
                w_state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (r_busy_s) begin
                    w_state_nxt = S_WAIT_LO;
                end else if (r_to_cnt == c_TO_W'(BUSY_TO - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_WAIT_LO: begin
                if (!r_busy_s)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_we          <= 1'b0;
            r_adr_lo      <= 16'h0000;
            r_data        <= 8'h00;
            r_wdm         <= 2'b00;
            r_vdp_dbi     <= 16'h0000;
            r_timeout_err <= 1'b0;
            r_to_cnt      <= '0;
            r_vdp_used    <= 1'b0;
            r_idle_used   <= 1'b0;
        end else begin
            if (w_grant) begin
                case (w_owner_nxt)
                    OWN_VDP: begin
                        r_we     <= ~vdp_we_n;
                        r_adr_lo <= vdp_adr[15:0];
                        r_data   <= vdp_dbo;
                        r_wdm    <= {~vdp_adr[16], vdp_adr[16]};
                    end
                    OWN_AUX: begin
                        r_we     <= w_aux_we;
                        r_adr_lo <= w_aux_adr[15:0];
                        r_data   <= w_aux_dbo;
                        r_wdm    <= {~w_aux_adr[16], w_aux_adr[16]};
                    end
                    default: r_we <= 1'b0;
                endcase
            end
            if (w_done && (r_owner == OWN_VDP) && !r_we)
                r_vdp_dbi <= mc_dout;
            r_timeout_err <= r_timeout_err | w_timeout;
            r_to_cnt      <= (r_state == S_WAIT_HI) ? r_to_cnt + 1'b1 : '0;
            // A slot is consumed by its first grant and re-armed once the phase ends.
            if (!slot_vdp)
                r_vdp_used <= 1'b0;
            else if (w_grant && (w_owner_nxt == OWN_VDP))
                r_vdp_used <= 1'b1;
            if (!slot_idle)
                r_idle_used <= 1'b0;
            else if (w_grant && (w_owner_nxt != OWN_VDP))
                r_idle_used <= 1'b1;
        end
    end

    assign w_wrap = (r_intv == c_INTV_W'(REFRESH_INTERVAL - 1));
    assign w_dec  = w_done && (r_owner == OWN_REF);

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_intv <= '0;
            r_debt <= '0;
        end else begin
            r_intv <= w_wrap ? '0 : r_intv + 1'b1;
            if (w_wrap && !w_dec && (r_debt != c_DEBT_W'(MAX_DEBT)))
                r_debt <= r_debt + 1'b1;
            else if (w_dec && !w_wrap && (r_debt != '0))
                r_debt <= r_debt - 1'b1;
        end
    end

    assign mc_addr     = {5'b00000, r_adr_lo};
    assign mc_din      = {r_data, r_data};
    assign mc_wdm      = r_wdm;
    assign vdp_dbi     = r_vdp_dbi;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// Testbench for vram_arbiter: reactive controller model plus a slot-level
// arbitration model (priority rules and refresh-debt arithmetic).
module tb_vram_arbiter;
    localparam int RI   = 200;
    localparam int MAXD = 4;
`ifdef VRAM_ARB_AUX_EN
    localparam bit AUX_EN = 1'b1;
`else
    localparam bit AUX_EN = 1'b0;
`endif

    logic        clk_w = 1'b0, reset_n_w = 1'b0;
    logic        slot_vdp = 1'b0, slot_idle = 1'b0, vdp_we_n = 1'b1;
    logic [16:0] vdp_adr = '0, aux_adr = '0;
    logic [7:0]  vdp_dbo = '0, aux_dbo = '0;
    logic        aux_req = 1'b0, aux_we = 1'b0, mc_busy = 1'b0;
    logic [15:0] mc_dout = '0;
    logic [15:0] vdp_dbi, mc_din;
    logic        aux_ack, mc_read, mc_write, mc_refresh, timeout_err;
    logic [7:0]  aux_dbi;
    logic [20:0] mc_addr;
    logic [1:0]  mc_wdm;

    vram_arbiter dut (
        .clk_w(clk_w), .reset_n_w(reset_n_w), .slot_vdp(slot_vdp), .slot_idle(slot_idle),
        .vdp_we_n(vdp_we_n), .vdp_adr(vdp_adr), .vdp_dbo(vdp_dbo), .vdp_dbi(vdp_dbi),
        .aux_req(aux_req), .aux_we(aux_we), .aux_adr(aux_adr), .aux_dbo(aux_dbo),
        .aux_ack(aux_ack), .aux_dbi(aux_dbi), .mc_read(mc_read), .mc_write(mc_write),
        .mc_refresh(mc_refresh), .mc_addr(mc_addr), .mc_din(mc_din), .mc_wdm(mc_wdm),
        .mc_dout(mc_dout), .mc_busy(mc_busy), .timeout_err(timeout_err)
    );

    always #5 clk_w = ~clk_w;

    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, m_debt = 0;
    bit          m_to = 1'b0;
    logic [15:0] m_vdp_dbi = '0;
    logic [7:0]  m_aux_dbi = '0;
    int          mc_phase = 0, mc_cnt = 0, d1_cfg = -1, d2_cfg = -1;
    bit          stuck = 1'b0, force_en = 1'b0;
    logic [15:0] force_val = '0, last_dout = '0;
    int          o_rd = 0, o_wr = 0, o_ref = 0, o_ack = 0;
    logic [20:0] o_addr = '0;
    logic [15:0] o_din = '0;
    logic [1:0]  o_wdm = '0;
    logic [7:0]  o_aux_dbi = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: count refresh credits, observe outputs and play the controller.
    task automatic step();
        @(negedge clk_w);
        if (reset_n_w) begin
            cyc++;
            if ((cyc % RI) == 0 && m_debt < MAXD) m_debt++;
        end
        if (mc_read || mc_write || mc_refresh) begin
            o_rd  += int'(mc_read);
            o_wr  += int'(mc_write);
            o_ref += int'(mc_refresh);
            o_addr = mc_addr;
            o_din  = mc_din;
            o_wdm  = mc_wdm;
            last_dout = force_en ? force_val : 16'($urandom);
            mc_dout  = last_dout;
            mc_phase = 1;
            mc_cnt   = (d1_cfg >= 0) ? d1_cfg : int'($urandom_range(0, 3));
        end else if (mc_phase == 1) begin
            if (!stuck) begin
                if (mc_cnt == 0) begin
                    mc_busy  = 1'b1;
                    mc_phase = 2;
                    mc_cnt   = (d2_cfg >= 0) ? d2_cfg : int'($urandom_range(1, 4));
                end else mc_cnt--;
            end
        end else if (mc_phase == 2) begin
            if (mc_cnt == 0) begin
                mc_busy  = 1'b0;
                mc_phase = 0;
            end else mc_cnt--;
        end
        if (aux_ack) begin
            o_ack++;
            o_aux_dbi = aux_dbi;
            aux_req   = 1'b0;
        end
    endtask

    task automatic clear_obs();
        o_rd = 0; o_wr = 0; o_ref = 0; o_ack = 0;
    endtask

    task automatic check_reset_outs(input string pfx);
        check_val({pfx, "_pulses"}, {mc_read, mc_write, mc_refresh, aux_ack, timeout_err}, 0);
        check_val({pfx, "_mc_addr"}, mc_addr, 0);
        check_val({pfx, "_din_wdm"}, {mc_din, mc_wdm}, 0);
        check_val({pfx, "_dbi"}, {vdp_dbi, aux_dbi}, 0);
    endtask

    // kind: 0 none, 1 VDP read, 2 VDP write, 3 refresh, 4 aux
    task automatic run_slot(input bit is_vdp);
        int          kind;
        logic [16:0] e_adr = '0;
        logic [7:0]  e_dat = '0;
        bit          e_we = 1'b0;
        if (!is_vdp)
            while ((cyc % RI) < 2 || (cyc % RI) > 150) step();
        clear_obs();
        if (is_vdp) begin
            kind = vdp_we_n ? 1 : 2;
            e_adr = vdp_adr; e_dat = vdp_dbo; e_we = !vdp_we_n;
        end else if (m_debt == MAXD) kind = 3;
        else if (AUX_EN && aux_req) begin
            kind = 4;
            e_adr = aux_adr; e_dat = aux_dbo; e_we = aux_we;
        end else if (m_debt > 0) kind = 3;
        else kind = 0;
        if (kind == 3) m_debt--;
        if (is_vdp) slot_vdp = 1'b1; else slot_idle = 1'b1;
        repeat (4) step();
        slot_vdp = 1'b0; slot_idle = 1'b0;
        repeat (30) step();
        if (stuck && kind != 0) m_to = 1'b1;
        if (kind == 1) m_vdp_dbi = last_dout;
        if (kind == 4 && !e_we) m_aux_dbi = e_adr[16] ? last_dout[15:8] : last_dout[7:0];
        check_val("rd_cnt", o_rd, (kind == 1) || (kind == 4 && !e_we));
        check_val("wr_cnt", o_wr, (kind == 2) || (kind == 4 && e_we));
        check_val("ref_cnt", o_ref, kind == 3);
        check_val("ack_cnt", o_ack, kind == 4);
        if (kind == 1 || kind == 2 || kind == 4) begin
            check_val("mc_addr", o_addr, {5'b0, e_adr[15:0]});
            check_val("mc_wdm", o_wdm, {~e_adr[16], e_adr[16]});
            if (e_we) check_val("mc_din", o_din, {e_dat, e_dat});
        end
        if (kind == 4 && !e_we) check_val("aux_dbi", o_aux_dbi, m_aux_dbi);
        check_val("vdp_dbi", vdp_dbi, m_vdp_dbi);
        check_val("timeout_err", timeout_err, m_to);
        stuck = 1'b0;
        mc_phase = 0;
    endtask

    task automatic raise_aux();
        aux_req = 1'b1;
        aux_we  = 1'($urandom);
        aux_adr = 17'($urandom);
        aux_dbo = 8'($urandom);
    endtask

    initial begin : main
        int w;
        repeat (3) step();
        check_reset_outs("por");
        reset_n_w = 1'b1;
        repeat (3) step();

        // Directed accesses
        force_en = 1'b1; force_val = 16'hA55A;
        vdp_we_n = 1'b1; vdp_adr = 17'h1_2345; vdp_dbo = 8'h77;
        run_slot(1'b1);
        vdp_we_n = 1'b0; vdp_adr = 17'h0_0010; vdp_dbo = 8'h3C;
        run_slot(1'b1);
        aux_req = 1'b1; aux_we = 1'b0; aux_adr = 17'h1_0000; aux_dbo = 8'h00;
        force_val = 16'hBE00;
        clear_obs();
        repeat (20) step();
        check_val("aux_no_slot", o_rd + o_wr + o_ref + o_ack, 0);
        vdp_we_n = 1'b1; vdp_adr = 17'h0_4321;
        run_slot(1'b1);
        run_slot(1'b0);
        force_en = 1'b0;

        // Controller never raises busy
        stuck = 1'b1; vdp_we_n = 1'b0; vdp_adr = 17'h0_0100; vdp_dbo = 8'h5A;
        run_slot(1'b1);
        vdp_we_n = 1'b1; vdp_adr = 17'h1_0200;
        run_slot(1'b1);

        // Reset in the middle of a read
        d1_cfg = 0; d2_cfg = 8;
        vdp_we_n = 1'b1; vdp_adr = 17'h0_0ABC;
        slot_vdp = 1'b1;
        w = 0;
        while (!mc_busy && w < 20) begin step(); w++; end
        check_val("busy_seen", mc_busy, 1);
        slot_vdp = 1'b0;
        repeat (3) step();
        #2 reset_n_w = 1'b0;
        #1 check_reset_outs("async");
        cyc = 0; m_debt = 0; m_to = 1'b0; m_vdp_dbi = '0; m_aux_dbi = '0;
        mc_busy = 1'b0; mc_phase = 0; aux_req = 1'b0; d1_cfg = -1; d2_cfg = -1;
        repeat (3) step();
        reset_n_w = 1'b1;
        clear_obs();
        repeat (20) step();
        check_val("no_spurious", o_rd + o_wr + o_ref + o_ack, 0);
        run_slot(1'b0);

        // Refresh debt saturation with aux pending
        raise_aux();
        repeat (5 * RI) step();
        repeat (6) run_slot(1'b0);

        // Randomised mix of slots
        for (int i = 0; i < 40; i++) begin
            if (!aux_req && $urandom_range(0, 2) == 0) raise_aux();
            vdp_we_n = 1'($urandom);
            vdp_adr  = 17'($urandom);
            vdp_dbo  = 8'($urandom);
            run_slot(1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
